// File: rtl/cdu_pkg.sv
// Shared types and defaults for the multi-channel CDU pulse accumulator.
// Channel names follow the AGC CDU ordering X, Y, Z, trunnion, shaft.
package cdu_pkg;

    localparam int CDU_NCHAN       = 5;
    localparam int CDU_WIDTH       = 15;
    localparam int CDU_SYNC_STAGES = 2;
    localparam int CDU_CHAN_W      = $clog2(CDU_NCHAN);

    typedef logic [CDU_CHAN_W-1:0] cdu_chan_t;
    typedef logic [CDU_WIDTH-1:0]  cdu_count_t;

    typedef enum logic [CDU_CHAN_W-1:0] {
        CDU_CH_X        = 3'd0,
        CDU_CH_Y        = 3'd1,
        CDU_CH_Z        = 3'd2,
        CDU_CH_TRUNNION = 3'd3,
        CDU_CH_SHAFT    = 3'd4
    } cdu_chan_e;

    // Packed so that {up, down} maps directly onto rd_wrap.
    typedef struct packed {
        logic up;
        logic down;
    } cdu_wrap_t;

endpackage

// File: rtl/cdu_pulse_edge.sv
// Synchroniser chain plus rising-edge detector for one asynchronous pulse line.
// A level held high produces a single one-cycle strobe.
module cdu_pulse_edge
    import cdu_pkg::*;
#(
    parameter int SYNC_STAGES = CDU_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cdu_pulse_accumulator.sv
// Multi-channel CDU angle accumulator: counts +/- dTheta pulse pairs into wrapping
// per-channel counters and serves them through a one-deep registered read port.
module cdu_pulse_accumulator
    import cdu_pkg::*;
#(
    parameter int  NCHAN       = CDU_NCHAN,
    parameter int  WIDTH       = CDU_WIDTH,
    parameter int  SYNC_STAGES = CDU_SYNC_STAGES,
    localparam int CHAN_W      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCHAN-1:0]  pulse_p,
    input  logic [NCHAN-1:0]  pulse_m,
    input  logic [NCHAN-1:0]  zero,
    input  logic              rd_req,
    input  logic [CHAN_W-1:0] rd_chan,
    input  logic              rd_clear,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic [1:0]        rd_wrap,
    output logic [NCHAN-1:0]  collide
);

    function automatic logic signed [1:0] edge_delta(input logic rp, input logic rm);
        if (rp && !rm) return 2'sd1;
        if (rm && !rp) return -2'sd1;
        return 2'sd0;
    endfunction

    // Modular add of a -1/0/+1 step; wraps naturally at 2^WIDTH.
    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cnt,
                                                    input logic signed [1:0] delta);
        return cnt + {{(WIDTH-2){delta[1]}}, delta};
    endfunction

    logic [NCHAN-1:0] rise_p;
    logic [NCHAN-1:0] rise_m;
    logic [WIDTH-1:0] cnt_all  [NCHAN];
    cdu_wrap_t        wrap_all [NCHAN];

    logic [WIDTH-1:0] sel_cnt;
    logic [1:0]       sel_wrap;

    logic             rd_vld_p1;
    logic [WIDTH-1:0] rd_data_p1;
    logic [1:0]       rd_wrap_p1;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        logic [WIDTH-1:0]  cnt_q;
        cdu_wrap_t         wrap_q;
        logic              col_q;
        logic signed [1:0] delta;
        logic              clr_hit;

        cdu_pulse_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_p (
            .clk   (clk),
            .rst   (rst),
            .pulse (pulse_p[g]),
            .rise  (rise_p[g])
        );

        cdu_pulse_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_m (
            .clk   (clk),
            .rst   (rst),
            .pulse (pulse_m[g]),
            .rise  (rise_m[g])
        );

        assign delta   = edge_delta(rise_p[g], rise_m[g]);
        assign clr_hit = rd_req && rd_clear && (rd_chan == CHAN_W'(g));

        // Zero beats clear-on-read; a clearing read keeps this cycle's step so no pulse is lost.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                wrap_q <= '0;
                col_q  <= 1'b0;
            end else if (zero[g]) begin
                cnt_q  <= '0;
                wrap_q <= '0;
            end else begin
                if (rise_p[g] && rise_m[g]) col_q <= 1'b1;
                if (clr_hit) begin
                    cnt_q  <= step_count('0, delta);
                    wrap_q <= '0;
                end else begin
                    cnt_q <= step_count(cnt_q, delta);
                    if (delta == 2'sd1 && cnt_q == '1) wrap_q.up <= 1'b1;
                    if (delta == -2'sd1 && cnt_q == '0) wrap_q.down <= 1'b1;
                end
            end
        end

        assign cnt_all[g]  = cnt_q;
        assign wrap_all[g] = wrap_q;
        assign collide[g]  = col_q;
    end

    // Out-of-range channels fall through to zero.
    always_comb begin
        sel_cnt  = '0;
        sel_wrap = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (rd_chan == CHAN_W'(i)) begin
                sel_cnt  = cnt_all[i];
                sel_wrap = wrap_all[i];
            end
        end
    end

    // ---- read stage p1: samples pre-update state, holds until the next response
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
            rd_wrap_p1 <= '0;
        end else begin
            rd_vld_p1 <= rd_req;
            if (rd_req) begin
                rd_data_p1 <= sel_cnt;
                rd_wrap_p1 <= sel_wrap;
            end
        end
    end

    assign rd_valid = rd_vld_p1;
    assign rd_data  = rd_data_p1;
    assign rd_wrap  = rd_wrap_p1;

endmodule

// File: tb/tb_cdu_pulse_accumulator.sv
// Directed self-checking bench for cdu_pulse_accumulator with hand-computed expectations.
module tb_cdu_pulse_accumulator;
    import cdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  pulse_p, pulse_m, zero;
    logic        rd_req, rd_clear;
    logic [2:0]  rd_chan;
    logic        rd_valid;
    logic [14:0] rd_data;
    logic [1:0]  rd_wrap;
    logic [4:0]  collide;

    int n_cmp = 0;
    int n_err = 0;

    int chans [6] = '{0, 1, 2, 3, 4, 7};
    int exp6  [6] = '{3, 0, 32'h7FFF, 1, 2, 0};

    always #5 clk = ~clk;

    cdu_pulse_accumulator dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_p  (pulse_p),
        .pulse_m  (pulse_m),
        .zero     (zero),
        .rd_req   (rd_req),
        .rd_chan  (rd_chan),
        .rd_clear (rd_clear),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_wrap  (rd_wrap),
        .collide  (collide)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One edge per two cycles; then let it pass the synchroniser.
    task automatic edges(input int ch, input int n, input bit minus);
        for (int k = 0; k < n; k++) begin
            if (minus) pulse_m[ch] = 1'b1; else pulse_p[ch] = 1'b1;
            tick(1);
            if (minus) pulse_m[ch] = 1'b0; else pulse_p[ch] = 1'b0;
            tick(1);
        end
        tick(4);
    endtask

    task automatic rd_check(input string tag, input int ch, input logic clr,
                            input logic [14:0] exp_d, input logic [1:0] exp_w);
        rd_req   = 1'b1;
        rd_chan  = 3'(ch);
        rd_clear = clr;
        tick(1);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"},  32'(rd_data),  32'(exp_d));
        chk({tag, "_wrap"},  32'(rd_wrap),  32'(exp_w));
        rd_req   = 1'b0;
        rd_clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pulse_p = '0; pulse_m = '0; zero = '0;
        rd_req = 1'b0; rd_clear = 1'b0; rd_chan = '0;
        tick(5);
        chk("rst_valid",   32'(rd_valid), 32'd0);
        chk("rst_data",    32'(rd_data),  32'd0);
        chk("rst_wrap",    32'(rd_wrap),  32'd0);
        chk("rst_collide", 32'(collide),  32'd0);
        rst = 1'b0;
        tick(2);

        // 100 up-counts on X, other channels untouched
        edges(int'(CDU_CH_X), 100, 1'b0);
        rd_check("t1_ch0", 0, 1'b0, 15'd100, 2'b00);
        for (int c = 1; c < 5; c++) rd_check("t1_other", c, 1'b0, 15'd0, 2'b00);

        // zero and clearing read together: zero wins, read sees pre-zero value
        zero[0] = 1'b1; rd_req = 1'b1; rd_chan = 3'd0; rd_clear = 1'b1;
        tick(1);
        zero[0] = 1'b0; rd_req = 1'b0; rd_clear = 1'b0;
        chk("zc_valid", 32'(rd_valid), 32'd1);
        chk("zc_data",  32'(rd_data),  32'd100);
        tick(1);
        rd_check("zc_after", 0, 1'b0, 15'd0, 2'b00);

        // wrap up then wrap down on Z
        edges(2, 32767, 1'b0);
        rd_check("t2_full", 2, 1'b0, 15'h7FFF, 2'b00);
        edges(2, 1, 1'b0);
        rd_check("t2_wrapup", 2, 1'b0, 15'h0000, 2'b10);
        edges(2, 1, 1'b1);
        rd_check("t2_wrapdn", 2, 1'b0, 15'h7FFF, 2'b11);
        zero[2] = 1'b1; tick(1); zero[2] = 1'b0; tick(1);
        rd_check("t2_zeroed", 2, 1'b0, 15'h0000, 2'b00);
        edges(2, 1, 1'b1);
        rd_check("t2_under", 2, 1'b0, 15'h7FFF, 2'b01);

        // simultaneous +/- on Y
        pulse_p[1] = 1'b1; pulse_m[1] = 1'b1;
        tick(2);
        pulse_p[1] = 1'b0; pulse_m[1] = 1'b0;
        tick(4);
        chk("t3_collide", 32'(collide), 32'h02);
        rd_check("t3_cnt", 1, 1'b0, 15'd0, 2'b00);

        // clearing read in the same cycle as a +strobe on trunnion
        edges(3, 5, 1'b0);
        pulse_p[3] = 1'b1; tick(1);
        pulse_p[3] = 1'b0; tick(1);
        rd_req = 1'b1; rd_chan = 3'd3; rd_clear = 1'b1;
        tick(1);
        chk("t4_valid", 32'(rd_valid), 32'd1);
        chk("t4_data",  32'(rd_data),  32'd5);
        rd_req = 1'b0; rd_clear = 1'b0;
        tick(3);
        rd_check("t4_after", 3, 1'b0, 15'd1, 2'b00);

        // held level counts once; short glitches counted at most once
        pulse_p[4] = 1'b1; tick(50); pulse_p[4] = 1'b0; tick(4);
        rd_check("t5_held", 4, 1'b0, 15'd1, 2'b00);
        #1 pulse_p[4] = 1'b1; #3 pulse_p[4] = 1'b0;
        @(negedge clk);
        #3 pulse_p[4] = 1'b1; #4 pulse_p[4] = 1'b0;
        @(negedge clk);
        tick(4);
        rd_check("t5_glitch", 4, 1'b0, 15'd2, 2'b00);

        edges(0, 3, 1'b0);

        // back-to-back reads including an out-of-range channel
        rd_req = 1'b1; rd_chan = 3'(chans[0]);
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("t6_valid", 32'(rd_valid), 32'd1);
            chk("t6_data",  32'(rd_data),  32'(exp6[i-1]));
            if (i < 6) rd_chan = 3'(chans[i]);
            else rd_req = 1'b0;
        end
        chk("t6_oor_wrap", 32'(rd_wrap), 32'd0);
        chk("t6_collide_held", 32'(collide), 32'h02);

        // reset landing on a request drops the response
        rd_req = 1'b1; rd_chan = 3'd3; rst = 1'b1;
        tick(1);
        rd_req = 1'b0;
        chk("t6_rst_valid", 32'(rd_valid), 32'd0);
        tick(4);
        rst = 1'b0;
        tick(1);
        chk("t6_rst_collide", 32'(collide), 32'd0);
        rd_check("t6_rst_cnt", 3, 1'b0, 15'd0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
